// File: rtl/mul_fp_arbiter.sv
// rtl/mul_fp_arbiter.sv - Round-robin sharing of one pipelined fp32 multiplier between requesters
//
// mul_fp: pipelined IEEE-754 single-precision multiply, q valid LATENCY cycles after a/b.
//   clk     in  clock
//   areset  in  synchronous active-high reset, flushes the result pipe
//   a, b    in  32-bit operands
//   q       out 32-bit product (round to nearest even, denormals flushed to zero)
//
// mul_fp_arbiter: round-robin issue of one multiply per cycle, tag pipe returns each product
// to its owner RSP_LAT = MUL_LATENCY+1 cycles after acceptance.
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   req_valid  in  per-requester operand pair valid
//   req_ready  out one-hot grant, combinational
//   req_a/b    in  per-requester operands
//   rsp_valid  out one-hot one-cycle response pulse
//   rsp_data   out product, shared bus, holds between pulses
//   busy       out any multiply in flight, including the delivery cycle
//   ops_done   out wrapping count of delivered responses

module mul_fp #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic               s;
        logic [7:0]         ex;
        logic [7:0]         ey;
        logic [47:0]        prod;
        logic [22:0]        frac;
        logic [23:0]        mant;
        logic               guard;
        logic               sticky;
        logic signed [10:0] e;
        s    = x[31] ^ y[31];
        ex   = x[30:23];
        ey   = y[30:23];
        prod = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
        e    = $signed({3'b0, ex}) + $signed({3'b0, ey}) - 11'sd127;
        // Product of two [1,2) mantissas lies in [1,4); normalise by one bit if needed.
        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            e      = e + 11'sd1;
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        mant = {1'b0, frac} + {23'b0, guard & (sticky | frac[0])};
        // Rounding carry out leaves frac at zero, only the exponent moves.
        if (mant[23]) e = e + 11'sd1;
        if ((ex == 8'hFF && x[22:0] != '0) || (ey == 8'hFF && y[22:0] != '0))
            fp_mul = 32'h7FC0_0000;
        else if (ex == 8'hFF || ey == 8'hFF)
            fp_mul = (ex == 8'h00 || ey == 8'h00) ? 32'h7FC0_0000 : {s, 8'hFF, 23'b0};
        else if (ex == 8'h00 || ey == 8'h00)
            fp_mul = {s, 31'b0};
        else if (e >= 11'sd255)
            fp_mul = {s, 8'hFF, 23'b0};
        else if (e <= 11'sd0)
            fp_mul = {s, 31'b0};
        else
            fp_mul = {s, e[7:0], mant[22:0]};
    endfunction

    logic [31:0] pipe [LATENCY];

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= fp_mul(a, b);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LATENCY-1];
endmodule

module mul_fp_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     busy,
    output logic [CNT_W-1:0]         ops_done
);
    localparam int RSP_LAT = MUL_LATENCY + 1;
    localparam int IW      = $clog2(NUM_REQ);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [31:0]        mul_q;
    logic [RSP_LAT-1:0] tag_vld;
    logic [IW-1:0]      tag_id [RSP_LAT];
    logic [NUM_REQ-1:0] dlv_onehot;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_any && req_valid[IW'((int'(ptr) + k) % NUM_REQ)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IW'((int'(ptr) + k) % NUM_REQ);
                end
            end
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        dlv_onehot = '0;
        dlv_onehot[tag_id[RSP_LAT-1]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            tag_vld   <= '0;
            for (int i = 0; i < RSP_LAT; i++) tag_id[i] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            ops_done  <= '0;
        end else begin
            // Tag stage 0 lines up with the operand register, the last stage with mul_q.
            tag_vld   <= {tag_vld[RSP_LAT-2:0], gnt_any};
            tag_id[0] <= gnt_idx;
            for (int i = 1; i < RSP_LAT; i++) tag_id[i] <= tag_id[i-1];
            if (gnt_any) begin
                op_a <= req_a[gnt_idx];
                op_b <= req_b[gnt_idx];
                ptr  <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            rsp_valid <= tag_vld[RSP_LAT-1] ? dlv_onehot : '0;
            if (tag_vld[RSP_LAT-1]) begin
                rsp_data <= mul_q;
                ops_done <= ops_done + 1'b1;
            end
        end
    end

    assign busy = (|tag_vld) || (|rsp_valid);

    mul_fp #(.LATENCY(MUL_LATENCY)) u_mul (
        .clk    (clk),
        .areset (rst),
        .a      (op_a),
        .b      (op_b),
        .q      (mul_q)
    );
endmodule

// File: tb/tb_mul_fp_arbiter.sv
// tb/tb_mul_fp_arbiter.sv - Randomized self-checking bench for mul_fp_arbiter
module tb_mul_fp_arbiter;
    localparam int N       = 4;
    localparam int ML      = 3;
    localparam int RSP_LAT = ML + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][31:0]   req_a = '0;
    logic [N-1:0][31:0]   req_b = '0;
    logic [N-1:0]         rsp_valid;
    logic [31:0]          rsp_data;
    logic                 busy;
    logic [15:0]          ops_done;

    logic [N-1:0]         w_valid = '0;
    logic [N-1:0]         w_ready;
    logic [N-1:0][31:0]   w_a = '0;
    logic [N-1:0][31:0]   w_b = '0;
    logic [N-1:0]         w_rsp_valid;
    logic [31:0]          w_rsp_data;
    logic                 w_busy;
    logic [3:0]           w_ops;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          due;
    } ent_t;

    ent_t        mq[$];
    int          cyc = 0;
    int          m_ptr = 0;
    int          m_ops = 0;
    logic [31:0] m_last = '0;
    logic [31:0] cur_prod [N];
    int          exp_gnt;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp_valid;
    logic [31:0] exp_rsp_data;
    logic        exp_busy;
    logic [15:0] exp_ops;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mul_fp_arbiter #(.NUM_REQ(N), .MUL_LATENCY(ML), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .ops_done(ops_done)
    );

    mul_fp_arbiter #(.NUM_REQ(N), .MUL_LATENCY(ML), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .req_valid(w_valid), .req_ready(w_ready),
        .req_a(w_a), .req_b(w_b), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
        .busy(w_busy), .ops_done(w_ops)
    );

    // Encode the exact value (-1)^s * n * 2^p as fp32 (n < 2^17, result normal).
    function automatic logic [31:0] enc(input bit s, input int unsigned n, input int p);
        int          k = 0;
        int unsigned t;
        for (int i = 0; i < 32; i++) if (n[i]) k = i;
        t = (n << (23 - k)) & 32'h007F_FFFF;
        return {s, 8'(k + p + 127), t[22:0]};
    endfunction

    task automatic compute_expect();
        while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
        exp_gnt   = -1;
        exp_ready = '0;
        if (!rst)
            for (int k = 0; k < N; k++)
                if (exp_gnt < 0 && req_valid[(m_ptr + k) % N]) exp_gnt = (m_ptr + k) % N;
        if (exp_gnt >= 0) exp_ready[exp_gnt] = 1'b1;
        exp_rsp_valid = '0;
        if (mq.size() > 0 && mq[0].due == cyc) exp_rsp_valid[mq[0].owner] = 1'b1;
        exp_rsp_data = m_last;
        exp_busy     = (mq.size() > 0);
        exp_ops      = 16'(m_ops);
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            bit          sa = 1'($urandom_range(1));
            bit          sb = 1'($urandom_range(1));
            int unsigned ma = $urandom_range(255, 1);
            int unsigned mb = $urandom_range(255, 1);
            int          pa = int'($urandom_range(40)) - 20;
            int          pb = int'($urandom_range(40)) - 20;
            req_a[i]    = enc(sa, ma, pa);
            req_b[i]    = enc(sb, mb, pb);
            cur_prod[i] = enc(sa ^ sb, ma * mb, pa + pb);
        end
        #1;
        compute_expect();
    endtask

    task automatic advance_edge();
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            m_ptr  = 0;
            m_ops  = 0;
            m_last = '0;
        end else begin
            if (exp_gnt >= 0) begin
                mq.push_back('{exp_gnt, cur_prod[exp_gnt], cyc + RSP_LAT});
                m_ptr = (exp_gnt + 1) % N;
            end
            while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
            if (mq.size() > 0 && mq[0].due == cyc) begin
                m_ops++;
                m_last = mq[0].data;
            end
        end
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 4'hF);
            vectors++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
            vectors++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
            vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
            vectors++; if (ops_done !== 16'h0) begin errors++; $display("FAIL reset_ops got=%h exp=0000", ops_done); end
            advance_edge();
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        drive(1'b0, 4'b0100);
        req_a[2]    = 32'h4000_0000;
        req_b[2]    = 32'h4040_0000;
        cur_prod[2] = enc(1'b0, 6, 0);
        vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        advance_edge();
        for (int n = 0; n < RSP_LAT + 2; n++) begin
            drive(1'b0, 4'b0);
            vectors++; if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL single_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp_valid); end
            vectors++; if (busy !== exp_busy) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            if (rsp_valid !== 4'b0) pulses++;
            if (exp_rsp_valid == 4'b0100) begin
                vectors++; if (rsp_data !== 32'h40C0_0000) begin errors++; $display("FAIL single_data got=%h exp=40c00000", rsp_data); end
            end
            advance_edge();
        end
        vectors++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        drive(1'b0, 4'b0);
        vectors++; if (ops_done !== 16'd1) begin errors++; $display("FAIL single_ops got=%0d exp=1", ops_done); end
        advance_edge();
    endtask

    task automatic test_round_robin();
        drive(1'b1, 4'b0);
        advance_edge();
        for (int n = 0; n < 8 + RSP_LAT + 2; n++) begin
            drive(1'b0, (n < 8) ? 4'hF : 4'h0);
            if (n < 8) begin
                vectors++; if (req_ready !== (4'b1 << (n % 4))) begin errors++; $display("FAIL rr_order n=%0d got=%b exp=%b", n, req_ready, 4'b1 << (n % 4)); end
            end
            vectors++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            vectors++; if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL rr_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp_valid); end
            vectors++; if (rsp_data !== exp_rsp_data) begin errors++; $display("FAIL rr_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_rsp_data); end
            advance_edge();
        end
    endtask

    task automatic test_streaming();
        int pulses = 0;
        for (int n = 0; n < 10 + RSP_LAT + 2; n++) begin
            drive(1'b0, (n < 10) ? 4'b0010 : 4'b0);
            vectors++; if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL stream_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp_valid); end
            vectors++; if (rsp_data !== exp_rsp_data) begin errors++; $display("FAIL stream_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_rsp_data); end
            vectors++; if (busy !== exp_busy) begin errors++; $display("FAIL stream_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            if (rsp_valid === 4'b0010) pulses++;
            advance_edge();
        end
        vectors++; if (pulses != 10) begin errors++; $display("FAIL stream_pulses got=%0d exp=10", pulses); end
    endtask

    task automatic test_reset_midflight();
        for (int n = 0; n < 4 + RSP_LAT + 2; n++) begin
            drive(n == 3, (n < 4) ? 4'hF : 4'h0);
            if (n > 3) begin
                vectors++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_rsp_valid cyc=%0d got=%b exp=0000", cyc, rsp_valid); end
            end
            vectors++; if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL mid_model cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp_valid); end
            advance_edge();
        end
        drive(1'b0, 4'hF);
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        advance_edge();
        for (int n = 0; n < RSP_LAT + 2; n++) begin
            drive(1'b0, 4'b0);
            vectors++; if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL mid_drain cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp_valid); end
            advance_edge();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(1'b0, (n < 290) ? N'($urandom) : N'(0));
            vectors++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            vectors++; if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp_valid); end
            vectors++; if (rsp_data !== exp_rsp_data) begin errors++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_rsp_data); end
            vectors++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            vectors++; if (ops_done !== exp_ops) begin errors++; $display("FAIL rnd_ops cyc=%0d got=%0d exp=%0d", cyc, ops_done, exp_ops); end
            advance_edge();
        end
    endtask

    task automatic test_wrap();
        int dl_prev = 0;
        int dl;
        w_a[0] = enc(1'b0, 1, 1);
        w_b[0] = enc(1'b0, 3, 0);
        drive(1'b1, 4'b0);
        advance_edge();
        for (int n = 0; n < 16 + RSP_LAT + 2; n++) begin
            drive(1'b0, 4'b0);
            w_valid = (n < 16) ? 4'b0001 : 4'b0000;
            dl = n - RSP_LAT;
            if (dl < 0) dl = 0;
            if (dl > 16) dl = 16;
            vectors++; if (w_ops !== 4'(dl)) begin errors++; $display("FAIL wrap_ops n=%0d got=%0d exp=%0d", n, w_ops, 4'(dl)); end
            vectors++; if (w_rsp_valid !== ((dl != dl_prev) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL wrap_rsp_valid n=%0d got=%b", n, w_rsp_valid); end
            if (dl != dl_prev) begin
                vectors++; if (w_rsp_data !== enc(1'b0, 6, 0)) begin errors++; $display("FAIL wrap_data n=%0d got=%h exp=40c00000", n, w_rsp_data); end
            end
            dl_prev = dl;
            advance_edge();
        end
        drive(1'b0, 4'b0);
        vectors++; if (w_busy !== 1'b0 || w_ready !== 4'b0) begin errors++; $display("FAIL wrap_idle busy=%b ready=%b exp=0/0000", w_busy, w_ready); end
        advance_edge();
    endtask

    initial begin
        @(posedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_streaming();
        test_reset_midflight();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
